// File: rtl/llr_debitrev.sv
// llr_debitrev: stores a serial LLR frame at bit-reversed addresses, drains it in natural order.
// Optional build macro LLR_DEBITREV_SAT_EN: when defined, the most negative LLR is stored as its symmetric counterpart.
module llr_debitrev #(
   parameter int N     = 256,
   parameter int LOG2N = 8,
   parameter int QW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vld_i,
   output logic          rdy_o,
   input  logic [QW-1:0] din,
   output logic          vld_o,
   input  logic          rdy_i,
   output logic [QW-1:0] dout,
   output logic          last_o,
   output logic          busy_o
);
   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
   state_t           state;
   logic [LOG2N-1:0] wcnt, rcnt, wadr;
   logic [QW-1:0]    wdat;
   logic [QW-1:0]    mem [N];
   // write address is the fill count with its bits mirrored
   always_comb begin
      wadr = '0;
      for (int j = 0; j < LOG2N; j++) wadr[j] = wcnt[LOG2N-1-j];
   end
`ifdef LLR_DEBITREV_SAT_EN
   assign wdat = (din == {1'b1, {(QW-1){1'b0}}}) ? {1'b1, {(QW-2){1'b0}}, 1'b1} : din;
`else
   assign wdat = din;
`endif
   // fill/drain sequencing; counters wrap naturally at N
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         wcnt  <= '0;
         rcnt  <= '0;
      end else
         case (state)
            IDLE: state <= FILL;
            FILL:
               if (vld_i) begin
                  wcnt <= wcnt + 1'b1;
                  if (wcnt == LOG2N'(N-1)) state <= DRAIN;
               end
            DRAIN:
               if (rdy_i) begin
                  rcnt <= rcnt + 1'b1;
                  if (rcnt == LOG2N'(N-1)) state <= FILL;
               end
            default: state <= IDLE;
         endcase
   // frame buffer is deliberately left uncleared by reset
   always_ff @(posedge clk)
      if (state == FILL && vld_i) mem[wadr] <= wdat;
   assign rdy_o  = state == FILL;
   assign vld_o  = state == DRAIN;
   assign dout   = vld_o ? mem[rcnt] : '0;
   assign last_o = vld_o && rcnt == LOG2N'(N-1);
   assign busy_o = (rdy_o && wcnt != '0) || vld_o;
endmodule
